demux8_dispatch: RTL and testbench

- 1-to-8 distributor: the inverse of the team's 8:1 select mux.
- Accepts one BUS_BITS word plus a 3-bit destination select over a valid/ready handshake.
- Steers the word into one of eight per-lane one-entry holding registers. Each lane presents its word downstream with its own valid/ready handshake.
- Used to route a single producer (e.g. writeback/forwarding result) to one of eight consumers without combinational fan-out glitches.

---
 rtl/demux8_dispatch_pkg.sv | 18 +
 rtl/demux8_dispatch_lane.sv | 33 +++
 rtl/demux8_dispatch.sv | 83 ++++++++
 tb/tb_demux8_dispatch.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/demux8_dispatch_pkg.sv
// Shared lane-count, select-width and occupancy definitions for the 1-to-8 dispatcher.
// Also provides a small population-count helper.
package demux8_dispatch_pkg;

    localparam int NUM_LANES = 8;
    localparam int SEL_BITS  = 3;
    localparam int OCC_BITS  = 4;

    function automatic logic [OCC_BITS-1:0] popcount8(input logic [NUM_LANES-1:0] v);
        logic [OCC_BITS-1:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            sum = sum + OCC_BITS'(v[i]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/demux8_dispatch_lane.sv
// One-entry holding register for a single dispatch lane.
// A load wins over a pop, so a same-cycle pop and reload keeps the lane full.
module demux_lane #(
    parameter int BUS_BITS = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic                i_pop,
    input  logic [BUS_BITS-1:0] i_data,
    output logic                o_full,
    output logic [BUS_BITS-1:0] o_data
);

    logic                r_full;
    logic [BUS_BITS-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/demux8_dispatch.sv
// 1-to-8 distributor: steers one valid/ready word into one of eight
// one-entry lanes, each drained by its own consumer handshake.
module demux8_dispatch
    import demux8_dispatch_pkg::*;
#(
    parameter int BUS_BITS = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_BITS-1:0]  in_data,
    input  logic [SEL_BITS-1:0]  in_sel,
    output logic [BUS_BITS-1:0]  out1,
    output logic [BUS_BITS-1:0]  out2,
    output logic [BUS_BITS-1:0]  out3,
    output logic [BUS_BITS-1:0]  out4,
    output logic [BUS_BITS-1:0]  out5,
    output logic [BUS_BITS-1:0]  out6,
    output logic [BUS_BITS-1:0]  out7,
    output logic [BUS_BITS-1:0]  out8,
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [OCC_BITS-1:0]  occupancy,
    output logic                 busy
);

    logic [NUM_LANES-1:0] w_full;
    logic [NUM_LANES-1:0] w_pop;
    logic [NUM_LANES-1:0] w_load;
    logic                 w_accept;
    logic [BUS_BITS-1:0]  w_lane_data [NUM_LANES];
    logic [OCC_BITS-1:0]  r_occ;

    // A lane can take a new word if it is empty or is being drained this cycle.
    assign in_ready = ~w_full[in_sel] | out_ready[in_sel];
    assign w_accept = in_valid & in_ready;
    assign w_pop    = w_full & out_ready;

    always_comb begin
        w_load = '0;
        if (w_accept) begin
            w_load[in_sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        demux_lane #(
            .BUS_BITS (BUS_BITS)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .i_load (w_load[k]),
            .i_pop  (w_pop[k]),
            .i_data (in_data),
            .o_full (w_full[k]),
            .o_data (w_lane_data[k])
        );
    end

    // Every accept adds one word (a full lane only accepts while popping), every pop removes one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + {{(OCC_BITS-1){1'b0}}, w_accept} - popcount8(w_pop);
        end
    end

    assign occupancy = r_occ;
    assign out_valid = w_full;
    assign busy      = |w_full;

    assign out1 = w_lane_data[0];
    assign out2 = w_lane_data[1];
    assign out3 = w_lane_data[2];
    assign out4 = w_lane_data[3];
    assign out5 = w_lane_data[4];
    assign out6 = w_lane_data[5];
    assign out7 = w_lane_data[6];
    assign out8 = w_lane_data[7];

endmodule

// File: tb/tb_demux8_dispatch.sv
// Self-checking bench for demux8_dispatch: directed scenarios followed by
// randomized traffic compared against a per-lane array model.
module tb_demux8_dispatch;

    localparam int BUS_BITS = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [BUS_BITS-1:0] in_data;
    logic [2:0]          in_sel;
    logic [BUS_BITS-1:0] out1, out2, out3, out4, out5, out6, out7, out8;
    logic [7:0]          out_valid;
    logic [7:0]          out_ready;
    logic [3:0]          occupancy;
    logic                busy;

    int n_chk  = 0;
    int n_fail = 0;

    bit          m_full [8];
    logic [63:0] m_data [8];
    bit          last_acc;

    always #5 clk = ~clk;

    demux8_dispatch #(.BUS_BITS(BUS_BITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .out6      (out6),
        .out7      (out7),
        .out8      (out8),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] lane_out(input int k);
        case (k)
            0: return out1;
            1: return out2;
            2: return out3;
            3: return out4;
            4: return out5;
            5: return out6;
            6: return out7;
            default: return out8;
        endcase
    endfunction

    // One clock of stimulus: drive just after an edge, check in_ready, advance the model, check state.
    task automatic cycle(input bit rst, input bit v, input logic [2:0] s,
                         input logic [63:0] d, input logic [7:0] rdy);
        bit          exp_rdy;
        bit          acc;
        int          cnt;
        logic [7:0]  exp_v;
        reset     = rst;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = rdy;
        #1;
        exp_rdy = !m_full[s] || rdy[s];
        acc     = v && exp_rdy && !rst;
        if (!rst) chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                m_full[k] = 1'b0;
                m_data[k] = '0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (m_full[k] && rdy[k]) m_full[k] = 1'b0;
            end
            if (acc) begin
                m_full[s] = 1'b1;
                m_data[s] = d;
            end
        end
        last_acc = acc;
        #1;
        cnt   = 0;
        exp_v = '0;
        for (int k = 0; k < 8; k++) begin
            exp_v[k] = m_full[k];
            cnt += int'(m_full[k]);
        end
        chk("out_valid", 64'(out_valid), 64'(exp_v));
        chk("occupancy", 64'(occupancy), 64'(cnt));
        chk("busy", 64'(busy), 64'(cnt != 0));
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("lane%0d_data", k + 1), lane_out(k), m_data[k]);
        end
    endtask

    initial begin
        bit          p_v;
        logic [2:0]  p_s;
        logic [63:0] p_d;
        logic [7:0]  rdy;
        int          density;

        for (int k = 0; k < 8; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = '0;
        end
        last_acc  = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles, then an idle cycle.
        cycle(1, 0, 3'd0, 64'd0, 8'h00);
        cycle(1, 0, 3'd0, 64'd0, 8'h00);
        chk("reset_occ", 64'(occupancy), 64'd0);
        cycle(0, 0, 3'd0, 64'd0, 8'h00);

        // Single dispatch to lane 6.
        cycle(0, 1, 3'd5, 64'hDEAD_BEEF_0000_0005, 8'h00);
        chk("single_vld", 64'(out_valid), 64'h20);
        chk("single_out6", out6, 64'hDEAD_BEEF_0000_0005);

        // Backpressure on lane 6, other lane still accepted.
        cycle(0, 1, 3'd5, 64'hDEAD_BEEF_0000_0005, 8'h00);
        chk("bp_accept", 64'(last_acc), 64'd0);
        cycle(0, 1, 3'd2, 64'h0000_0000_0000_0022, 8'h00);
        chk("bp_occ", 64'(occupancy), 64'd2);
        cycle(0, 0, 3'd0, 64'd0, 8'hFF);

        // Same-lane stream with the consumer always ready.
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 1, 3'd3, 64'(i), 8'h08);
            chk("stream_out4", out4, 64'(i));
            chk("stream_vld4", 64'(out_valid[3]), 64'd1);
        end
        cycle(0, 0, 3'd0, 64'd0, 8'hFF);

        // Fill all lanes, then drain in one cycle.
        for (int i = 0; i < 8; i++) cycle(0, 1, 3'(i), 64'h100 + 64'(i), 8'h00);
        chk("fill_occ", 64'(occupancy), 64'd8);
        chk("fill_busy", 64'(busy), 64'd1);
        cycle(0, 0, 3'd0, 64'd0, 8'hFF);
        chk("drain_occ", 64'(occupancy), 64'd0);

        // Reset together with a transfer to lane 8.
        for (int i = 0; i < 4; i++) cycle(0, 1, 3'(i), 64'h200 + 64'(i), 8'h00);
        cycle(1, 1, 3'd7, 64'h77, 8'h00);
        chk("rstmid_vld", 64'(out_valid), 64'd0);
        chk("rstmid_out8", out8, 64'd0);

        // Randomized traffic; a refused offer is held stable until taken.
        p_v = 1'b0;
        p_s = '0;
        p_d = '0;
        density = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) density = int'($urandom_range(10, 95));
            rdy = '0;
            for (int k = 0; k < 8; k++) rdy[k] = ($urandom_range(0, 99) < density);
            if (!(p_v && !last_acc)) begin
                p_v = ($urandom_range(0, 99) < 75);
                p_s = 3'($urandom_range(0, 7));
                p_d = {$urandom, $urandom};
            end
            if ($urandom_range(0, 499) == 0) begin
                cycle(1, p_v, p_s, p_d, rdy);
                p_v = 1'b0;
            end else begin
                cycle(0, p_v, p_s, p_d, rdy);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
